// File: rtl/bus_router_if.sv
// Bus bundle for bus_router: Wishbone host port, per-bank core channels, per-bank memory ports.
// Latency: none, signal container only.
// Backpressure: Wishbone classic; a request is held until the matching ack/err arrives.
interface bus_router_if #(
   parameter int NUM_BANKS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   // host port
   logic                             host_cyc_i;
   logic                             host_stb_i;
   logic                             host_we_i;
   logic [ADDR_WIDTH-1:0]            host_addr_i;
   logic [DATA_WIDTH-1:0]            host_data_i;
   logic [DATA_WIDTH-1:0]            host_data_o;
   logic                             host_ack_o;
   logic                             host_err_o;
   // core channels, channel k at slice k
   logic [NUM_BANKS-1:0]             core_cyc_i;
   logic [NUM_BANKS-1:0]             core_stb_i;
   logic [NUM_BANKS-1:0]             core_we_i;
   logic [NUM_BANKS*ADDR_WIDTH-1:0]  core_addr_i;
   logic [NUM_BANKS*DATA_WIDTH-1:0]  core_data_i;
   logic [NUM_BANKS*DATA_WIDTH-1:0]  core_data_o;
   logic [NUM_BANKS-1:0]             core_ack_o;
   // memory banks, bank k at slice k
   logic [NUM_BANKS-1:0]             mem_cyc_o;
   logic [NUM_BANKS-1:0]             mem_stb_o;
   logic [NUM_BANKS-1:0]             mem_we_o;
   logic [NUM_BANKS*ADDR_WIDTH-1:0]  mem_addr_o;
   logic [NUM_BANKS*DATA_WIDTH-1:0]  mem_data_o;
   logic [NUM_BANKS*DATA_WIDTH-1:0]  mem_data_i;
   logic [NUM_BANKS-1:0]             mem_ack_i;

   // router side
   modport slave (
      input  host_cyc_i, host_stb_i, host_we_i, host_addr_i, host_data_i,
      output host_data_o, host_ack_o, host_err_o,
      input  core_cyc_i, core_stb_i, core_we_i, core_addr_i, core_data_i,
      output core_data_o, core_ack_o,
      output mem_cyc_o, mem_stb_o, mem_we_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i
   );

   // environment side (host, cores, memories)
   modport master (
      output host_cyc_i, host_stb_i, host_we_i, host_addr_i, host_data_i,
      input  host_data_o, host_ack_o, host_err_o,
      output core_cyc_i, core_stb_i, core_we_i, core_addr_i, core_data_i,
      input  core_data_o, core_ack_o,
      input  mem_cyc_o, mem_stb_o, mem_we_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i
   );
endinterface

// File: rtl/bus_router.sv
// Routes memory banks to either the core channels (combinational pass-through) or a single Wishbone host.
// Latency: host request accepted in N, mem_stb in N+1, mem ack in M gives host ack/err in M+1; core path 0 cycles.
// Backpressure: host waits on the bank ack up to TIMEOUT_CYCLES, then gets err; core channels see memory ack directly.
module bus_router #(
   parameter int NUM_BANKS      = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  host_sel_i,
   bus_router_if.slave           bus,
   input  logic [ADDR_WIDTH-1:0] end_position_i,
   input  logic [ADDR_WIDTH-1:0] match_mask_i,
   input  logic                  clear_finish_i,
   output logic                  finish_o,
   output logic [31:0]           core_access_count_o
);

   localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                state_q, state_d;
   logic                  owner_q;
   logic                  err_q, err_d;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  we_q;
   logic [SEL_W-1:0]      bank_q;
   logic [SEL_W-1:0]      host_bank;
   logic                  bank_ok;
   logic [15:0]           tmo_q;
   logic                  host_req;
   logic                  mem_ack_sel;
   logic                  timeout_hit;
   logic [NUM_BANKS-1:0]  core_ack;
   logic                  finish_hit;
   logic [3:0]            ack_cnt;
   logic [32:0]           cnt_sum;

   // Decode host bank from the top address bits; a single bank always decodes to 0.
   always_comb begin
      host_bank = '0;
      if (NUM_BANKS > 1) host_bank = bus.host_addr_i[ADDR_WIDTH-1 -: SEL_W];
   end

   assign bank_ok     = ({1'b0, host_bank} < (SEL_W+1)'(NUM_BANKS));
   assign host_req    = bus.host_cyc_i & bus.host_stb_i;
   assign mem_ack_sel = bus.mem_ack_i[bank_q];
   assign timeout_hit = (tmo_q == 16'(TIMEOUT_CYCLES - 1));

   // Host FSM next state: an ack on the last wait cycle still counts as a normal completion.
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (host_req) begin
               if (!owner_q && bank_ok) begin
                  state_d = REQ;
                  err_d   = 1'b0;
                  accept  = 1'b1;
               end else begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end
            end
         end
         REQ: begin
            if (mem_ack_sel) begin
               state_d = RESP;
               err_d   = 1'b0;
            end else if (timeout_hit) begin
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Host FSM state, request latches, wait counter and ownership; ownership only moves while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
         owner_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         bank_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (state_q == IDLE) owner_q <= host_sel_i;
         if (accept) begin
            addr_q  <= bus.host_addr_i;
            wdata_q <= bus.host_data_i;
            we_q    <= bus.host_we_i;
            bank_q  <= host_bank;
            tmo_q   <= '0;
         end else if (state_q == REQ) begin
            tmo_q <= tmo_q + 16'd1;
         end
         if (state_q == REQ && mem_ack_sel && !we_q)
            rdata_q <= bus.mem_data_i[bank_q*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign bus.host_ack_o  = (state_q == RESP) && !err_q;
   assign bus.host_err_o  = (state_q == RESP) &&  err_q;
   assign bus.host_data_o = rdata_q;

   // Bank muxing: core channels pass straight through when they own the banks, else only the latched host bank is driven.
   always_comb begin
      bus.mem_cyc_o   = '0;
      bus.mem_stb_o   = '0;
      bus.mem_we_o    = '0;
      bus.mem_addr_o  = '0;
      bus.mem_data_o  = '0;
      bus.core_data_o = '0;
      core_ack        = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (owner_q) begin
            bus.mem_cyc_o[k] = bus.core_cyc_i[k];
            bus.mem_stb_o[k] = bus.core_stb_i[k];
            bus.mem_we_o[k]  = bus.core_we_i[k];
            bus.mem_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH]  = bus.core_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            bus.mem_data_o[k*DATA_WIDTH +: DATA_WIDTH]  = bus.core_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            bus.core_data_o[k*DATA_WIDTH +: DATA_WIDTH] = bus.mem_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            core_ack[k] = bus.mem_ack_i[k];
         end else if (state_q == REQ && bank_q == SEL_W'(k)) begin
            bus.mem_cyc_o[k] = 1'b1;
            bus.mem_stb_o[k] = 1'b1;
            bus.mem_we_o[k]  = we_q;
            bus.mem_addr_o[k*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
            bus.mem_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
         end
      end
   end

   assign bus.core_ack_o = core_ack;

   // Finish match on any active core channel, and per-cycle count of core acks.
   always_comb begin
      finish_hit = 1'b0;
      ack_cnt    = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (owner_q && bus.core_cyc_i[k] && bus.core_stb_i[k] &&
             ((bus.core_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] & match_mask_i) == (end_position_i & match_mask_i)))
            finish_hit = 1'b1;
         ack_cnt = ack_cnt + 4'(core_ack[k]);
      end
      cnt_sum = {1'b0, core_access_count_o} + 33'(ack_cnt);
   end

   // Sticky finish flag and saturating access counter; clear wins over a same-cycle update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         finish_o            <= 1'b0;
         core_access_count_o <= '0;
      end else if (clear_finish_i) begin
         finish_o            <= 1'b0;
         core_access_count_o <= '0;
      end else begin
         finish_o            <= finish_o | finish_hit;
         core_access_count_o <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
      end
   end

endmodule

// File: tb/tb_bus_router.sv
// Directed bench for bus_router: host read/write/timeout, ownership handover, finish detect, access count, reset abort.
// Latency: inputs change and outputs are sampled on the falling clock edge.
// Backpressure: memory acks are driven directly by the stimulus sequence.
module tb_bus_router;
   localparam int NB = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic        clk;
   logic        rst_n;
   logic        host_sel;
   logic [31:0] end_position;
   logic [31:0] match_mask;
   logic        clear_finish;
   logic        finish;
   logic [31:0] access_count;

   int n_vec = 0;
   int n_bad = 0;

   bus_router_if #(.NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bus_router #(
      .NUM_BANKS(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .host_sel_i          (host_sel),
      .bus                 (bus.slave),
      .end_position_i      (end_position),
      .match_mask_i        (match_mask),
      .clear_finish_i      (clear_finish),
      .finish_o            (finish),
      .core_access_count_o (access_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic host_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
      bus.host_cyc_i  = 1'b1;
      bus.host_stb_i  = 1'b1;
      bus.host_we_i   = we;
      bus.host_addr_i = addr;
      bus.host_data_i = data;
   endtask

   task automatic host_drop();
      bus.host_cyc_i = 1'b0;
      bus.host_stb_i = 1'b0;
      bus.host_we_i  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      host_sel = 1'b0;
      end_position = '0;
      match_mask = '0;
      clear_finish = 1'b0;
      bus.host_cyc_i = 1'b0;
      bus.host_stb_i = 1'b0;
      bus.host_we_i = 1'b0;
      bus.host_addr_i = '0;
      bus.host_data_i = '0;
      bus.core_cyc_i = '0;
      bus.core_stb_i = '0;
      bus.core_we_i = '0;
      bus.core_addr_i = '0;
      bus.core_data_i = '0;
      bus.mem_data_i = '0;
      bus.mem_ack_i = '0;

      // reset state
      #12;
      check("rst_ack",    64'(bus.host_ack_o), 64'h0);
      check("rst_err",    64'(bus.host_err_o), 64'h0);
      check("rst_data",   64'(bus.host_data_o), 64'h0);
      check("rst_finish", 64'(finish), 64'h0);
      check("rst_count",  64'(access_count), 64'h0);
      check("rst_memcyc", 64'(bus.mem_cyc_o), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // host read of bank 1, memory acks one cycle after stb
      host_req(1'b0, 32'h8000_0010, 32'h0);
      @(negedge clk);
      check("rd_memcyc",  64'(bus.mem_cyc_o), 64'h2);
      check("rd_memstb",  64'(bus.mem_stb_o), 64'h2);
      check("rd_memwe",   64'(bus.mem_we_o), 64'h0);
      check("rd_addr1",   64'(bus.mem_addr_o[63:32]), 64'h8000_0010);
      check("rd_addr0",   64'(bus.mem_addr_o[31:0]), 64'h0);
      @(negedge clk);
      check("rd_noack",   64'(bus.host_ack_o), 64'h0);
      bus.mem_ack_i = 2'b10;
      bus.mem_data_i[63:32] = 32'hDEAD_BEEF;
      @(negedge clk);
      check("rd_ack",     64'(bus.host_ack_o), 64'h1);
      check("rd_err",     64'(bus.host_err_o), 64'h0);
      check("rd_data",    64'(bus.host_data_o), 64'hDEAD_BEEF);
      check("rd_idle",    64'(bus.mem_cyc_o), 64'h0);
      host_drop();
      bus.mem_ack_i = 2'b00;
      @(negedge clk);
      check("rd_ackpulse", 64'(bus.host_ack_o), 64'h0);

      // host write to bank 0 with no memory ack: times out after 4 wait cycles
      host_req(1'b1, 32'h0000_0020, 32'h55AA_55AA);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("wr_memcyc", 64'(bus.mem_cyc_o), 64'h1);
         check("wr_noerr",  64'(bus.host_err_o), 64'h0);
      end
      check("wr_memwe",   64'(bus.mem_we_o), 64'h1);
      check("wr_wdata",   64'(bus.mem_data_o[31:0]), 64'h55AA_55AA);
      @(negedge clk);
      check("tmo_err",    64'(bus.host_err_o), 64'h1);
      check("tmo_ack",    64'(bus.host_ack_o), 64'h0);
      check("tmo_memcyc", 64'(bus.mem_cyc_o), 64'h0);
      check("tmo_keep",   64'(bus.host_data_o), 64'hDEAD_BEEF);
      host_drop();
      @(negedge clk);
      check("tmo_errpulse", 64'(bus.host_err_o), 64'h0);

      // ownership request during REQ takes effect only after the response
      host_req(1'b0, 32'h0000_0004, 32'h0);
      @(negedge clk);
      check("own_req",    64'(bus.mem_cyc_o), 64'h1);
      host_sel = 1'b1;
      bus.mem_ack_i = 2'b01;
      bus.mem_data_i[31:0] = 32'h1111_2222;
      bus.core_cyc_i = 2'b01;
      bus.core_stb_i = 2'b01;
      bus.core_addr_i[31:0] = 32'h0000_0100;
      @(negedge clk);
      check("own_ack",    64'(bus.host_ack_o), 64'h1);
      check("own_data",   64'(bus.host_data_o), 64'h1111_2222);
      check("own_resp",   64'(bus.mem_cyc_o), 64'h0);
      host_drop();
      bus.mem_ack_i = 2'b00;
      @(negedge clk);
      check("own_hold",   64'(bus.mem_cyc_o), 64'h0);
      @(negedge clk);
      check("own_pass",   64'(bus.mem_cyc_o), 64'h1);
      check("own_paddr",  64'(bus.mem_addr_o[31:0]), 64'h100);

      // finish detection on channel 1
      bus.core_cyc_i = 2'b10;
      bus.core_stb_i = 2'b10;
      bus.core_addr_i[63:32] = 32'h0000_0041;
      end_position = 32'h1234_5640;
      match_mask = 32'h0000_003F;
      bus.mem_data_i[63:32] = 32'hCAFE_F00D;
      #1;
      check("fin_pre",    64'(finish), 64'h0);
      check("fin_cdata",  64'(bus.core_data_o[63:32]), 64'hCAFE_F00D);
      check("fin_paddr",  64'(bus.mem_addr_o[63:32]), 64'h41);
      @(negedge clk);
      check("fin_nomatch", 64'(finish), 64'h0);
      bus.core_addr_i[63:32] = 32'h0000_0040;
      @(negedge clk);
      check("fin_set",    64'(finish), 64'h1);
      bus.core_cyc_i = 2'b00;
      bus.core_stb_i = 2'b00;
      @(negedge clk);
      check("fin_sticky", 64'(finish), 64'h1);
      clear_finish = 1'b1;
      @(negedge clk);
      check("fin_clear",  64'(finish), 64'h0);
      clear_finish = 1'b0;

      // both channels acked for 3 cycles; host request meanwhile is refused
      bus.mem_ack_i = 2'b11;
      host_req(1'b0, 32'h8000_0000, 32'h0);
      #1;
      check("cnt_coreack", 64'(bus.core_ack_o), 64'h3);
      @(negedge clk);
      check("cnt_herr",   64'(bus.host_err_o), 64'h1);
      check("cnt_hack",   64'(bus.host_ack_o), 64'h0);
      check("cnt_2",      64'(access_count), 64'd2);
      host_drop();
      @(negedge clk);
      check("cnt_4",      64'(access_count), 64'd4);
      @(negedge clk);
      check("cnt_6",      64'(access_count), 64'd6);
      bus.mem_ack_i = 2'b00;
      @(negedge clk);
      check("cnt_hold",   64'(access_count), 64'd6);
      bus.mem_ack_i = 2'b11;
      clear_finish = 1'b1;
      @(negedge clk);
      check("cnt_clrprio", 64'(access_count), 64'd0);
      clear_finish = 1'b0;
      bus.mem_ack_i = 2'b00;

      // hand banks back to host, then reset in the middle of a host read
      host_sel = 1'b0;
      @(negedge clk);
      bus.mem_ack_i = 2'b11;
      #1;
      check("host_own_coreack", 64'(bus.core_ack_o), 64'h0);
      check("host_own_coredat", 64'(bus.core_data_o), 64'h0);
      bus.mem_ack_i = 2'b00;
      host_req(1'b0, 32'h8000_0008, 32'h0);
      @(negedge clk);
      check("ra_req",     64'(bus.mem_cyc_o), 64'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("ra_memcyc",  64'(bus.mem_cyc_o), 64'h0);
      check("ra_memstb",  64'(bus.mem_stb_o), 64'h0);
      check("ra_ack",     64'(bus.host_ack_o), 64'h0);
      check("ra_err",     64'(bus.host_err_o), 64'h0);
      check("ra_data",    64'(bus.host_data_o), 64'h0);
      check("ra_count",   64'(access_count), 64'h0);
      host_drop();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ra_noresp", 64'(bus.host_ack_o | bus.host_err_o), 64'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
